// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative shift-add multiply / restoring divide with architectural HI/LO registers
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;
    state_t state, nextState;
    logic [2:0] opReg;
    logic [WIDTH-1:0] aReg, bReg, upper, lower, aMag, bMag, quot, rem, inSrc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0] mulSum, divTrial;
    logic [2*WIDTH-1:0] prod, accum;
    logic signedOp, isDiv, aNeg, bNeg, idle, accept, mtStart, inDiv, divFits;
    assign idle = state == IDLE;
    assign accept = Start && idle && (!Op[3] || Op[3:1] == 3'b100);
    assign mtStart = accept && Op[3];
    assign inDiv = Op[2:1] == 2'b01;
    assign inSrc = inDiv ? A : B;
    assign signedOp = !opReg[0];
    assign isDiv = opReg[2:1] == 2'b01;
    assign aNeg = signedOp && aReg[WIDTH-1];
    assign bNeg = signedOp && bReg[WIDTH-1];
    assign aMag = aNeg ? -aReg : aReg;
    assign bMag = bNeg ? -bReg : bReg;
    assign mulSum = {1'b0, upper} + (lower[0] ? {1'b0, aMag} : '0);
    assign divTrial = {upper, lower[WIDTH-1]} - {1'b0, bMag};
    assign divFits = !divTrial[WIDTH];
    assign prod = (aNeg ^ bNeg) ? -{upper, lower} : {upper, lower};
    assign accum = !opReg[2] ? prod : opReg[1] ? {Hi, Lo} - prod : {Hi, Lo} + prod;
    assign quot = (aNeg ^ bNeg) ? -lower : lower;
    assign rem = aNeg ? -upper : upper;
    assign Busy = !idle;
    // State register
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else state <= nextState;
    end
    // Next state: accept a multiply/divide, run WIDTH radix-2 steps, then one finalise cycle
    always_comb begin
        nextState = state;
        if (accept && !Op[3]) nextState = CALC;
        else if (state == CALC && cnt == '0) nextState = FINAL;
        else if (state == FINAL) nextState = IDLE;
    end
    // Operand capture, iteration datapath and HI/LO write-back
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Hi <= '0;
            Lo <= '0;
            Done <= 1'b0;
            DivByZero <= 1'b0;
            cnt <= '0;
            opReg <= '0;
            aReg <= '0;
            bReg <= '0;
            upper <= '0;
            lower <= '0;
        end else begin
            Done <= mtStart || state == FINAL;
            if (accept) DivByZero <= 1'b0;
            if (accept && !Op[3]) begin
                opReg <= Op[2:0];
                aReg <= A;
                bReg <= B;
                cnt <= CNT_W'(WIDTH - 1);
                upper <= '0;
                lower <= (!Op[0] && inSrc[WIDTH-1]) ? -inSrc : inSrc;
            end
            if (mtStart && !Op[0]) Hi <= A;
            if (mtStart && Op[0]) Lo <= A;
            if (state == CALC) begin
                if (cnt != '0) cnt <= cnt - 1'b1;
                if (isDiv) begin
                    upper <= divFits ? divTrial[WIDTH-1:0] : {upper[WIDTH-2:0], lower[WIDTH-1]};
                    lower <= {lower[WIDTH-2:0], divFits};
                end else begin
                    upper <= mulSum[WIDTH:1];
                    lower <= {mulSum[0], lower[WIDTH-1:1]};
                end
            end
            if (state == FINAL) begin
                if (isDiv && bReg == '0) begin
                    Hi <= aReg;
                    Lo <= '1;
                    DivByZero <= 1'b1;
                end else if (isDiv) begin
                    Hi <= rem;
                    Lo <= quot;
                end else begin
                    {Hi, Lo} <= accum;
                end
            end
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: scoreboard bench for the HI/LO multiply/divide unit
module tb_hilo_muldiv_unit;
    localparam int W = 32;
    localparam logic [3:0] MULT = 0, MULTU = 1, DIV = 2, DIVU = 3, MADD = 4, MADDU = 5;
    localparam logic [3:0] MSUB = 6, MSUBU = 7, MTHI = 8, MTLO = 9, RSVD = 12;
    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic dbz;
    } exp_t;
    logic Clk = 1'b0;
    logic Reset = 1'b1, Start = 1'b0;
    logic [3:0] Op = '0;
    logic [W-1:0] A = '0, B = '0;
    logic Busy, Done, DivByZero;
    logic [W-1:0] Hi, Lo;
    exp_t sbQ[$];
    int total = 0, bad = 0;
    int busyCycles;

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expectResult(input logic [W-1:0] h, input logic [W-1:0] l, input logic d);
        exp_t e;
        e.hi = h;
        e.lo = l;
        e.dbz = d;
        sbQ.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1;
        Op = op;
        A = a;
        B = b;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbQ.size() != 0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding, want 0", sbQ.size());
            sbQ.delete();
        end
        @(negedge Clk);
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation
    always @(negedge Clk) begin
        exp_t e;
        if (Done) begin
            chk("done_with_busy", 64'(Busy), 64'd0);
            if (sbQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: Done=1 with no outstanding op, want Done=0");
            end else begin
                e = sbQ.pop_front();
                chk("hi", 64'(Hi), 64'(e.hi));
                chk("lo", 64'(Lo), 64'(e.lo));
                chk("divbyzero", 64'(DivByZero), 64'(e.dbz));
            end
        end
    end

    initial begin
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        chk("reset_hi", 64'(Hi), 64'd0);
        chk("reset_lo", 64'(Lo), 64'd0);
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_done", 64'(Done), 64'd0);
        chk("reset_dbz", 64'(DivByZero), 64'd0);

        expectResult(32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        issue(MULT, 32'hFFFF_FFFD, 32'd5);
        busyCycles = 0;
        while (Busy && busyCycles < 100) begin
            busyCycles++;
            @(negedge Clk);
        end
        chk("mult_busy_cycles", 64'(busyCycles), 64'd33);
        drain();
        chk("done_single_pulse", 64'(Done), 64'd0);

        expectResult(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        expectResult(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        drain();

        expectResult(32'd100, 32'hFFFF_FFFF, 1'b1);
        issue(DIVU, 32'd100, 32'd0);
        drain();
        chk("dbz_sticky", 64'(DivByZero), 64'd1);

        expectResult(32'd0, 32'hFFFF_FFFF, 1'b0);
        issue(MTHI, 32'd0, 32'd0);
        chk("dbz_cleared_on_start", 64'(DivByZero), 64'd0);
        drain();
        expectResult(32'd0, 32'd10, 1'b0);
        issue(MTLO, 32'd10, 32'd0);
        drain();
        expectResult(32'd0, 32'd22, 1'b0);
        issue(MADD, 32'd3, 32'd4);
        drain();

        expectResult(32'd0, 32'd0, 1'b0);
        issue(MTLO, 32'd0, 32'd0);
        drain();
        expectResult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        issue(MSUBU, 32'd1, 32'd1);
        drain();

        expectResult(32'd0, 32'h8000_0000, 1'b0);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();
        expectResult(32'd1, 32'hFFFF_FFFD, 1'b0);
        issue(DIV, 32'd7, 32'hFFFF_FFFE);
        drain();
        expectResult(32'd2, 32'd14, 1'b0);
        issue(DIVU, 32'd100, 32'd7);
        drain();
        expectResult(32'd2, 32'd20, 1'b0);
        issue(MSUB, 32'hFFFF_FFFE, 32'd3);
        drain();

        expectResult(32'd0, 32'd20, 1'b0);
        issue(MTHI, 32'd0, 32'd0);
        drain();
        expectResult(32'd0, 32'hFFFF_FFFF, 1'b0);
        issue(MTLO, 32'hFFFF_FFFF, 32'd0);
        drain();
        expectResult(32'd1, 32'd0, 1'b0);
        issue(MADDU, 32'd1, 32'd1);
        drain();

        issue(RSVD, 32'h5555_5555, 32'd1);
        chk("reserved_no_busy", 64'(Busy), 64'd0);
        repeat (3) @(negedge Clk);
        chk("reserved_hi", 64'(Hi), 64'd1);
        chk("reserved_lo", 64'(Lo), 64'd0);

        expectResult(32'd0, 32'd6, 1'b0);
        issue(MULT, 32'd2, 32'd3);
        repeat (3) @(negedge Clk);
        chk("hi_held_during_calc", 64'(Hi), 64'd1);
        issue(MTHI, 32'h0000_1234, 32'd0);
        drain();
        chk("hi_after_ignored_mthi", 64'(Hi), 64'd0);

        issue(DIV, 32'd50, 32'd7);
        repeat (9) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midop_reset_busy", 64'(Busy), 64'd0);
        chk("midop_reset_hi", 64'(Hi), 64'd0);
        chk("midop_reset_lo", 64'(Lo), 64'd0);
        chk("midop_reset_done", 64'(Done), 64'd0);
        Reset = 1'b0;
        repeat (40) @(negedge Clk);
        chk("after_reset_idle", 64'(Busy), 64'd0);
        chk("after_reset_lo", 64'(Lo), 64'd0);

        expectResult(32'd1, 32'd0, 1'b0);
        issue(MULTU, 32'h0001_0000, 32'h0001_0000);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the execute stage.
- Replaces the single-cycle HI/LO path with iterative shift-add multiply and restoring divide.
- Supports signed/unsigned MULT, DIV, MADD, MSUB, plus MTHI/MTLO.
- Busy/Done handshake lets the hazard unit stall MFHI/MFLO and further HI/LO ops.

Parameters:
- WIDTH, 32, operand and HI/LO register width (must be ≥4 and even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; accepted only on an edge where Busy=0.
- Op  in  4  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU, 8 MTHI, 9 MTLO; 10-15 reserved.
- A  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source).
- B  in  WIDTH  rt operand (multiplier / divisor).
- Busy  out  1  iteration in progress.
- Done  out  1  one-cycle pulse: HI/LO just updated.
- DivByZero  out  1  sticky until next accepted Start; set when a DIV/DIVU has B=0.
- Hi  out  WIDTH  HI register, registered output.
- Lo  out  WIDTH  LO register, registered output.

Behaviour:
- Reset (any cycle, including mid-operation):
  - State=IDLE; Hi=Lo=0; Busy=Done=DivByZero=0; counter=0.
  - Any in-flight operation is discarded.
- States: IDLE, CALC, FINAL.
- IDLE:
  - Start=1 with Op 0-7: latch A, B, Op at edge E0 and go to CALC.
  - Start=1 with Op 8/9: write Hi (or Lo) with A at E0, stay in IDLE, Done=1 for the next cycle.
  - Reserved Op: ignored, no Done.
- CALC:
  - Exactly WIDTH cycles (edges E1..E_WIDTH), one radix-2 step per edge, counter counts WIDTH-1 down to 0.
  - Multiply uses operand magnitudes, 2*WIDTH-bit product.
  - Divide uses restoring divide on magnitudes.
  - Then go to FINAL.
- FINAL: one edge (E_WIDTH+1):
  - Apply sign correction.
  - Write Hi/Lo.
  - Return to IDLE.
  - Done=1 during the following cycle.
- Busy=1 while state is CALC or FINAL. Total latency from accept edge to HI/LO update is WIDTH+1 cycles.
- Start while Busy=1 is ignored; no queuing.
- Hi/Lo hold their old values throughout CALC, so MFHI/MFLO are stalled by Busy externally.
- Signed multiply: product negated when A[W-1]^B[W-1].
- MULT/MULTU: {Hi,Lo} = product.
- MADD*/MSUB*: {Hi,Lo} = {Hi,Lo} ± product, wrap modulo 2^(2W), no overflow flag.
  - The accumulate operand is the {Hi,Lo} value sampled at FINAL, which equals the value at accept.
- Divide results:
  - Lo = quotient, truncated toward zero.
  - Hi = remainder, with the sign of the dividend.
  - Signed -2^(W-1) / -1: Lo=0x80..0, Hi=0 (wraps, no trap).
- Divide by zero:
  - Still runs full latency.
  - Lo = all-ones, Hi = A.
  - DivByZero=1 from FINAL until the next accepted Start.
- Done is never asserted in the same cycle as Busy.
- Done rises only once per accepted operation.

Test Plan:
- Reset, then MULT A=0xFFFFFFFD (-3), B=5 -> Busy high 33 cycles; Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; Done pulses once.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIVU A=100, B=0 -> Lo=0xFFFFFFFF, Hi=100, DivByZero=1; it clears on the next Start.
- MTHI 0, MTLO 10, then MADD A=3, B=4 -> Hi=0, Lo=22 (MTHI/MTLO each Done after 1 cycle).
- MSUBU from Hi=0, Lo=0, A=1, B=1 -> Hi=Lo=0xFFFFFFFF (wrap).
- Start MULT; assert Start with Op=MTHI at cycle 5 -> ignored, Hi unchanged.
- Assert Reset at cycle 10 of a DIV -> Busy=0 next cycle, Hi=Lo=0, no Done.
